// File: rtl/modred_arbiter.sv
// Round-robin scheduler that shares one Barrett reducer among NUM_REQ requesters.
// Each job is sequenced through clear, run and capture, with a RUN-cycle watchdog.
module modred_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int WIDTH   = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*2*WIDTH-1:0] req_a,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [WIDTH-1:0]           rsp_r,
    output logic                       rsp_err,
    output logic                       red_reset,
    output logic                       red_enable,
    output logic [2*WIDTH-1:0]         red_a,
    input  logic                       red_done,
    input  logic [WIDTH-1:0]           red_r,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        RESP
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [ID_W-1:0]    r_last_grant;
    logic [ID_W-1:0]    r_id;
    logic [2*WIDTH-1:0] r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rsp_r;
    logic               r_rsp_err;
    logic               r_timeout_err;

    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_grant;
    logic               w_grant_found;
    logic [2*WIDTH-1:0] w_grant_op;
    logic               w_accept;
    logic               w_timeout_hit;
    logic               w_handshake;

    // Walk offsets from the farthest down to 1 so the nearest requester after
    // last_grant overwrites any earlier candidate.
    always_comb begin
        w_idx         = '0;
        w_grant       = '0;
        w_grant_found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_grant       = w_idx;
                w_grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_grant_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_grant_op = req_a[i*2*WIDTH +: 2*WIDTH];
            end
        end
    end

    assign w_accept      = (r_state == IDLE) && w_grant_found && !reset;
    assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_handshake   = (r_state == RESP) && rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = CLEAR;
            CLEAR:   w_next_state = RUN;
            RUN:     if (red_done || w_timeout_hit) w_next_state = RESP;
            RESP:    if (w_handshake) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // red_reset follows the module reset so an in-flight reducer job is discarded too.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_accept && (w_grant == ID_W'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
        rsp_valid  = (r_state == RESP);
        red_reset  = reset || (r_state == CLEAR);
        red_enable = (r_state == RUN);
        busy       = (r_state != IDLE);
    end

    // A completing reducer wins over the watchdog when both fire in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant  <= ID_W'(NUM_REQ - 1);
            r_id          <= '0;
            r_op          <= '0;
            r_cnt         <= '0;
            r_rsp_r       <= '0;
            r_rsp_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op <= w_grant_op;
                        r_id <= w_grant;
                    end
                end
                CLEAR: begin
                    r_cnt <= '0;
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (red_done) begin
                        r_rsp_r   <= red_r;
                        r_rsp_err <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_rsp_r       <= '0;
                        r_rsp_err     <= 1'b1;
                        r_timeout_err <= 1'b1;
                    end
                end
                RESP: begin
                    if (w_handshake) begin
                        r_last_grant <= r_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_id      = r_id;
    assign rsp_r       = r_rsp_r;
    assign rsp_err     = r_rsp_err;
    assign red_a       = r_op;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_modred_arbiter.sv
// Directed bench for modred_arbiter with a behavioural reducer (p = 37) whose
// completion latency is adjustable, including a never-completing mode.
module tb_modred_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 8;

    logic                       clk;
    logic                       reset;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*2*WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [ID_W-1:0]            rsp_id;
    logic [WIDTH-1:0]           rsp_r;
    logic                       rsp_err;
    logic                       red_reset;
    logic                       red_enable;
    logic [2*WIDTH-1:0]         red_a;
    logic                       red_done;
    logic [WIDTH-1:0]           red_r;
    logic                       busy;
    logic                       timeout_err;

    logic [2*WIDTH-1:0] reqA [NUM_REQ];
    int vecCount = 0;
    int errCount = 0;
    int redCnt = 0;
    int redLatency = 3;
    logic [2*WIDTH-1:0] modulus = 32'd37;

    modred_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W),
        .WIDTH  (WIDTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_r      (rsp_r),
        .rsp_err    (rsp_err),
        .red_reset  (red_reset),
        .red_enable (red_enable),
        .red_a      (red_a),
        .red_done   (red_done),
        .red_r      (red_r),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign req_a = {reqA[3], reqA[2], reqA[1], reqA[0]};

    // Reducer model: done goes high once it has been enabled redLatency cycles.
    always @(posedge clk) begin
        if (red_reset) redCnt <= 0;
        else if (red_enable) redCnt <= redCnt + 1;
    end
    assign red_done = (redCnt >= redLatency);
    assign red_r    = WIDTH'(red_a % modulus);

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge with the DUT idle; runs one job through handshake.
    task automatic applyStimulus(input logic [3:0] mask, input int grant, input int lat,
                                 input logic [WIDTH-1:0] expR, input logic expErr,
                                 input int stall, input logic drop);
        int n;
        logic [3:0] expReady;
        req_valid = mask;
        #1;
        expReady = 4'b0001 << grant;
        checkOutput("grant", req_ready, expReady);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if (drop) req_valid[grant] = 1'b0;
                checkOutput("clearRedReset", red_reset, 1);
                checkOutput("clearNoReady", req_ready, 0);
            end
            if (n == 2) begin
                checkOutput("runEnable", red_enable, 1);
                checkOutput("runOperand", red_a, reqA[grant]);
            end
        end while (!rsp_valid && n < 40);
        checkOutput("latency", n, lat);
        checkOutput("rspId", rsp_id, grant);
        checkOutput("rspR", rsp_r, expR);
        checkOutput("rspErr", rsp_err, expErr);
        checkOutput("respEnableLow", red_enable, 0);
        checkOutput("respOperandHeld", red_a, reqA[grant]);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("stallValid", rsp_valid, 1);
            checkOutput("stallId", rsp_id, grant);
            checkOutput("stallR", rsp_r, expR);
            checkOutput("stallNoReady", req_ready, 0);
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("handshakeNoReady", req_ready, 0);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("idleValid", rsp_valid, 0);
        checkOutput("idleBusy", busy, 0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        reqA[0]   = 32'd500;
        reqA[1]   = 32'd1000;
        reqA[2]   = 32'd2024;
        reqA[3]   = 32'd77777;
        repeat (3) @(negedge clk);
        checkOutput("rstReady", req_ready, 0);
        checkOutput("rstValid", rsp_valid, 0);
        checkOutput("rstRedReset", red_reset, 1);
        checkOutput("rstEnable", red_enable, 0);
        checkOutput("rstRedA", red_a, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstTimeout", timeout_err, 0);
        reset = 1'b0;
        #1;
        checkOutput("relRedReset", red_reset, 0);

        $display("[TB] round robin with all requesters active");
        applyStimulus(4'b1111, 0, 6, 16'd19, 1'b0, 0, 1'b0);
        applyStimulus(4'b1111, 1, 6, 16'd1,  1'b0, 0, 1'b0);
        applyStimulus(4'b1111, 2, 6, 16'd26, 1'b0, 0, 1'b0);
        applyStimulus(4'b1111, 3, 6, 16'd3,  1'b0, 0, 1'b0);
        applyStimulus(4'b1111, 0, 6, 16'd19, 1'b0, 0, 1'b0);

        $display("[TB] single requester");
        applyStimulus(4'b0010, 1, 6, 16'd1, 1'b0, 0, 1'b1);

        $display("[TB] response backpressure");
        applyStimulus(4'b1111, 2, 6, 16'd26, 1'b0, 10, 1'b0);

        $display("[TB] done coincides with watchdog limit");
        redLatency = 7;
        applyStimulus(4'b1000, 3, 10, 16'd3, 1'b0, 0, 1'b1);
        checkOutput("coincideNoTimeout", timeout_err, 0);

        $display("[TB] watchdog abort");
        redLatency = 1000;
        applyStimulus(4'b0001, 0, 10, 16'd0, 1'b1, 0, 1'b1);
        checkOutput("timeoutSet", timeout_err, 1);
        redLatency = 3;
        applyStimulus(4'b0011, 1, 6, 16'd1, 1'b0, 0, 1'b1);
        checkOutput("timeoutSticky", timeout_err, 1);

        $display("[TB] reset during RUN");
        req_valid = 4'b0100;
        #1;
        checkOutput("preResetGrant", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        checkOutput("preResetRun", red_enable, 1);
        reset     = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        checkOutput("midRstReady", req_ready, 0);
        checkOutput("midRstValid", rsp_valid, 0);
        checkOutput("midRstId", rsp_id, 0);
        checkOutput("midRstR", rsp_r, 0);
        checkOutput("midRstErr", rsp_err, 0);
        checkOutput("midRstEnable", red_enable, 0);
        checkOutput("midRstRedA", red_a, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstTimeout", timeout_err, 0);
        checkOutput("midRstRedReset", red_reset, 1);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("postRstNoOrphan", rsp_valid, 0);
        applyStimulus(4'b1111, 0, 6, 16'd19, 1'b0, 0, 1'b0);
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
